vga_bounce_renderer: RTL and testbench

//  Pixel stage directly downstream of the VGA timing generator: consumes x/y/video_on/frame_pulse/hsync/vsync.

---
 rtl/vga_bounce_renderer.sv | 123 ++++++++++++
 tb/tb_vga_bounce_renderer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vga_bounce_renderer.sv
// vga_bounce_renderer: bouncing-box pixel stage with 2-clk aligned rgb/hsync/vsync; `COLOR_CYCLE_EN adds a bounce-driven palette
module vga_bounce_renderer #(
  parameter int H_DISPLAY = 640,
  parameter int V_DISPLAY = 480,
  parameter int BOX_W = 32,
  parameter int BOX_H = 32,
  parameter int SPEED = 4,
  parameter int INIT_X = 100,
  parameter int INIT_Y = 50,
  parameter logic [11:0] BOX_COLOR = 12'hF80,
  parameter logic [11:0] BG_COLOR = 12'h003
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        frame_pulse,
  input  logic        pause,
  output logic [11:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic [9:0]  box_x,
  output logic [9:0]  box_y,
  output logic [7:0]  bounce_count,
  output logic        corner_hit
);
  localparam logic [10:0] X_MAX = 11'(H_DISPLAY - BOX_W);
  localparam logic [10:0] Y_MAX = 11'(V_DISPLAY - BOX_H);
  localparam logic [10:0] STEP = 11'(SPEED);
  localparam logic [10:0] BW = 11'(BOX_W);
  localparam logic [10:0] BH = 11'(BOX_H);
  logic        dir_x, dir_y;
  logic [9:0]  disp_x, disp_y;
  logic [10:0] x_sum, y_sum;
  logic        hit_x, hit_y, step, bounce;
  logic [9:0]  nx_x, nx_y;
  logic        s1_in, s1_von, s1_hs, s1_vs;
  logic [11:0] box_colour;
  // next position and wall hits for each axis; dir 1 means moving toward larger coordinates
  always_comb begin
    step = frame_pulse && !pause;
    x_sum = {1'b0, box_x} + STEP;
    y_sum = {1'b0, box_y} + STEP;
    hit_x = dir_x ? x_sum >= X_MAX : {1'b0, box_x} <= STEP;
    hit_y = dir_y ? y_sum >= Y_MAX : {1'b0, box_y} <= STEP;
    nx_x = dir_x ? (hit_x ? X_MAX[9:0] : x_sum[9:0]) : (hit_x ? 10'd0 : box_x - STEP[9:0]);
    nx_y = dir_y ? (hit_y ? Y_MAX[9:0] : y_sum[9:0]) : (hit_y ? 10'd0 : box_y - STEP[9:0]);
    bounce = step && (hit_x || hit_y);
  end
  // motion state advances once per unpaused frame; a corner counts as a single bounce
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      box_x <= 10'(INIT_X);
      box_y <= 10'(INIT_Y);
      dir_x <= 1'b1;
      dir_y <= 1'b1;
      bounce_count <= 8'd0;
      corner_hit <= 1'b0;
    end else begin
      corner_hit <= step && hit_x && hit_y;
      if (step) begin
        box_x <= nx_x;
        box_y <= nx_y;
        dir_x <= hit_x ? !dir_x : dir_x;
        dir_y <= hit_y ? !dir_y : dir_y;
      end
      if (bounce && bounce_count != 8'hFF) bounce_count <= bounce_count + 8'd1;
    end
  end
  // displayed position only changes at the vsync falling edge, inside vertical blanking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_x <= 10'(INIT_X);
      disp_y <= 10'(INIT_Y);
    end else if (s1_vs && !vsync_in) begin
      disp_x <= box_x;
      disp_y <= box_y;
    end
  end
  // stage 1: box hit test and sync capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_in <= 1'b0;
      s1_von <= 1'b0;
      s1_hs <= 1'b1;
      s1_vs <= 1'b1;
    end else begin
      s1_in <= {1'b0, x} >= {1'b0, disp_x} && {1'b0, x} < {1'b0, disp_x} + BW &&
               {1'b0, y} >= {1'b0, disp_y} && {1'b0, y} < {1'b0, disp_y} + BH;
      s1_von <= video_on;
      s1_hs <= hsync_in;
      s1_vs <= vsync_in;
    end
  end
  // stage 2: colour select and aligned syncs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb <= 12'h000;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      rgb <= !s1_von ? 12'h000 : s1_in ? box_colour : BG_COLOR;
      hsync <= s1_hs;
      vsync <= s1_vs;
    end
  end
`ifdef COLOR_CYCLE_EN
  logic [1:0] pal_idx;
  // palette index steps on every bounce frame, wrapping after four colours
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pal_idx <= 2'd0;
    else if (bounce) pal_idx <= pal_idx + 2'd1;
  end
  // palette lookup
  always_comb box_colour = pal_idx == 2'd0 ? BOX_COLOR : pal_idx == 2'd1 ? 12'h0F0 :
                           pal_idx == 2'd2 ? 12'h0FF : 12'hF0F;
`else
  assign box_colour = BOX_COLOR;
`endif
endmodule

// File: tb/tb_vga_bounce_renderer.sv
// tb_vga_bounce_renderer: random and directed stimulus on three configurations checked against a frame-level model
module tb_vga_bounce_renderer;
  logic clk = 0, reset_n = 0;
  logic [9:0] x = 0, y = 0;
  logic video_on = 0, hsync_in = 1, vsync_in = 1, frame_pulse = 0, pause = 0;
  logic [11:0] rgb_o [3];
  logic hs_o [3], vs_o [3], cor_o [3];
  logic [9:0] bx_o [3], by_o [3];
  logic [7:0] bc_o [3];
  int checks = 0, errors = 0;
  int PW [3] = '{32, 32, 636};
  int PH [3] = '{32, 32, 476};
  int IX [3] = '{100, 604, 100};
  int IY [3] = '{50, 444, 50};
  int mx [3], my [3], mdx [3], mdy [3], mcnt [3], mdpx [3], mdpy [3], mpal [3], erg [3];
  bit mcor [3], s1_in [3];
  bit s1_von, s1_hs, s1_vs, ehs, evs;

  always #5 clk = ~clk;

  vga_bounce_renderer u0 (.clk(clk), .reset_n(reset_n), .x(x), .y(y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .frame_pulse(frame_pulse), .pause(pause),
    .rgb(rgb_o[0]), .hsync(hs_o[0]), .vsync(vs_o[0]), .box_x(bx_o[0]), .box_y(by_o[0]),
    .bounce_count(bc_o[0]), .corner_hit(cor_o[0]));
  vga_bounce_renderer #(.INIT_X(604), .INIT_Y(444)) u1 (.clk(clk), .reset_n(reset_n), .x(x), .y(y),
    .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in), .frame_pulse(frame_pulse),
    .pause(pause), .rgb(rgb_o[1]), .hsync(hs_o[1]), .vsync(vs_o[1]), .box_x(bx_o[1]),
    .box_y(by_o[1]), .bounce_count(bc_o[1]), .corner_hit(cor_o[1]));
  vga_bounce_renderer #(.BOX_W(636), .BOX_H(476)) u2 (.clk(clk), .reset_n(reset_n), .x(x), .y(y),
    .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in), .frame_pulse(frame_pulse),
    .pause(pause), .rgb(rgb_o[2]), .hsync(hs_o[2]), .vsync(vs_o[2]), .box_x(bx_o[2]),
    .box_y(by_o[2]), .bounce_count(bc_o[2]), .corner_hit(cor_o[2]));

  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic int colour(int p);
`ifdef COLOR_CYCLE_EN
    int pal [4] = '{'hF80, 'h0F0, 'h0FF, 'hF0F};
    return pal[p];
`else
    return 'hF80 + p * 0;
`endif
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      mx[i] = IX[i]; my[i] = IY[i]; mdx[i] = 1; mdy[i] = 1; mcnt[i] = 0;
      mdpx[i] = IX[i]; mdpy[i] = IY[i]; mpal[i] = 0; erg[i] = 0; mcor[i] = 0; s1_in[i] = 0;
    end
    s1_von = 0; s1_hs = 1; s1_vs = 1; ehs = 1; evs = 1;
  endfunction

  // one axis move: returns 1 on a wall bounce
  function automatic bit move(inout int p, inout int d, input int lim);
    if (d > 0) begin
      if (p + 4 >= lim) begin p = lim; d = -1; return 1; end
      p += 4;
    end else begin
      if (p <= 4) begin p = 0; d = 1; return 1; end
      p -= 4;
    end
    return 0;
  endfunction

  function automatic void model_step();
    bit latch, bx, by;
    latch = s1_vs && !vsync_in;
    for (int i = 0; i < 3; i++) begin
      erg[i] = !s1_von ? 0 : s1_in[i] ? colour(mpal[i]) : 'h003;
      s1_in[i] = x >= mdpx[i] && x < mdpx[i] + PW[i] && y >= mdpy[i] && y < mdpy[i] + PH[i];
      if (latch) begin mdpx[i] = mx[i]; mdpy[i] = my[i]; end
      mcor[i] = 0;
      if (frame_pulse && !pause) begin
        bx = move(mx[i], mdx[i], 640 - PW[i]);
        by = move(my[i], mdy[i], 480 - PH[i]);
        mcor[i] = bx && by;
        if (bx || by) begin
          mcnt[i] = mcnt[i] == 255 ? 255 : mcnt[i] + 1;
          mpal[i] = (mpal[i] + 1) % 4;
        end
      end
    end
    ehs = s1_hs; evs = s1_vs;
    s1_von = video_on; s1_hs = hsync_in; s1_vs = vsync_in;
  endfunction

  task automatic compare();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d rgb", i), 32'(rgb_o[i]), erg[i]);
      check($sformatf("u%0d hsync", i), 32'(hs_o[i]), 32'(ehs));
      check($sformatf("u%0d vsync", i), 32'(vs_o[i]), 32'(evs));
      check($sformatf("u%0d box_x", i), 32'(bx_o[i]), mx[i]);
      check($sformatf("u%0d box_y", i), 32'(by_o[i]), my[i]);
      check($sformatf("u%0d bounce_count", i), 32'(bc_o[i]), mcnt[i]);
      check($sformatf("u%0d corner_hit", i), 32'(cor_o[i]), 32'(mcor[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset_n) model_reset(); else model_step();
    #1 compare();
  endtask

  task automatic quiet();
    x = 0; y = 0; video_on = 0; hsync_in = 1; vsync_in = 1; frame_pulse = 0; pause = 0;
  endtask

  task automatic rnd_inputs();
    int xi, yi;
    video_on = $urandom_range(0, 3) != 0;
    xi = $urandom_range(0, 1) ? mdpx[0] + int'($urandom_range(0, 35)) - 2 : int'($urandom_range(0, 639));
    yi = $urandom_range(0, 1) ? mdpy[0] + int'($urandom_range(0, 35)) - 2 : int'($urandom_range(0, 479));
    xi = xi < 0 ? 0 : xi > 639 ? 639 : xi;
    yi = yi < 0 ? 0 : yi > 479 ? 479 : yi;
    x = video_on ? 10'(xi) : 10'd0;
    y = video_on ? 10'(yi) : 10'd0;
    if ($urandom_range(0, 9) == 0) hsync_in = !hsync_in;
    if ($urandom_range(0, 39) == 0) vsync_in = !vsync_in;
    if ($urandom_range(0, 99) == 0) pause = !pause;
    frame_pulse = $urandom_range(0, 3) == 0;
  endtask

  task automatic pulse();
    frame_pulse = 1; tick();
    frame_pulse = 0; tick();
  endtask

  initial begin
    model_reset();
    repeat (2) tick();
    reset_n = 1;
    repeat (40) begin rnd_inputs(); tick(); end
    // asynchronous reset mid-cycle: outputs drop before the next edge
    reset_n = 0;
    #1 model_reset();
    compare();
    check("T1 rgb", 32'(rgb_o[0]), 0);
    check("T1 hsync", 32'(hs_o[0]), 1);
    check("T1 vsync", 32'(vs_o[0]), 1);
    check("T1 box_x", 32'(bx_o[0]), 100);
    check("T1 box_y", 32'(by_o[0]), 50);
    check("T1 bounce_count", 32'(bc_o[0]), 0);
    quiet();
    repeat (2) tick();
    reset_n = 1;
    // latency and colour
    vsync_in = 0; tick();
    vsync_in = 1; tick();
    x = 100; y = 50; video_on = 1; hsync_in = 0; tick();
    check("T2 rgb before latency", 32'(rgb_o[0]), 0);
    check("T2 hsync before latency", 32'(hs_o[0]), 1);
    x = 132; hsync_in = 1; tick();
    check("T2 rgb box", 32'(rgb_o[0]), 'hF80);
    check("T2 hsync delayed", 32'(hs_o[0]), 0);
    x = 0; y = 0; video_on = 0; tick();
    check("T2 rgb background", 32'(rgb_o[0]), 'h003);
    check("T2 hsync restored", 32'(hs_o[0]), 1);
    tick();
    check("T2 rgb blank", 32'(rgb_o[0]), 0);
    // right wall on u0, corner on u1
    for (int i = 0; i < 127; i++) begin
      frame_pulse = 1; tick();
      if (i == 0) begin
        check("T4 box_x", 32'(bx_o[1]), 608);
        check("T4 box_y", 32'(by_o[1]), 448);
        check("T4 bounce_count", 32'(bc_o[1]), 1);
        check("T4 corner_hit", 32'(cor_o[1]), 1);
      end
      frame_pulse = 0; tick();
      if (i == 0) check("T4 corner_hit single", 32'(cor_o[1]), 0);
      if (i == 1) begin
        check("T4 return x", 32'(bx_o[1]), 604);
        check("T4 return y", 32'(by_o[1]), 444);
      end
    end
    check("T3 box_x wall", 32'(bx_o[0]), 608);
    check("T3 model wall", mx[0], 608);
    pulse();
    check("T3 box_x after", 32'(bx_o[0]), 604);
    // pause ignores pulses
    pause = 1;
    repeat (3) pulse();
    check("T5 paused box_x", 32'(bx_o[0]), 604);
    pause = 0;
    pulse();
    check("T5 resumed box_x", 32'(bx_o[0]), 600);
    repeat (8000) begin rnd_inputs(); tick(); end
    check("T6 saturation", 32'(bc_o[2]), 255);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
